// File: rtl/seq_det_pkg.sv
// Shared constants and the match-length function for the serial sequence detector.
package seq_det_pkg;

    // Default build: pattern 1010, states count matched bits 0..4.
    localparam int              DEFAULT_W       = 4;
    localparam logic [3:0]      DEFAULT_PATTERN = 4'b1010;
    localparam int              STATE_W         = $clog2(DEFAULT_W + 1);

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,  // idle
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1010" detect
    } state_e;

    // Longest proper border of the pattern (prefix that is also a suffix).
    // The pattern is held right-aligned; its MSB (bit pw-1) is received first.
    function automatic int border_len(input logic [15:0] p, input int pw);
        int best;
        best = 0;
        for (int l = 1; l < pw; l++) begin
            logic ok;
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (p[pw-1-i] != p[pw-1-(pw-l+i)]) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Next matched length from 'state' after receiving 'in_bit'. Out-of-range
    // states fall back to idle; the full-match state restarts either from the
    // border (overlapping) or from idle.
    function automatic int next_match_len(input logic [15:0] p, input int pw,
                                          input int overlap, input int state,
                                          input int in_bit);
        int k;
        int best;
        if (state > pw) return 0;
        if (state == pw) k = (overlap != 0) ? border_len(p, pw) : 0;
        else             k = state;
        best = 0;
        // Candidate string: first k pattern bits followed by in_bit (length k+1).
        for (int l = 1; l <= k + 1; l++) begin
            logic ok;
            ok = (l <= pw);
            for (int i = 0; i < l; i++) begin
                int   j;
                logic sb;
                j  = k + 1 - l + i;
                sb = (j < k) ? p[pw-1-j] : in_bit[0];
                if (l <= pw && sb != p[pw-1-i]) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational (state, bit) -> next state lookup, table built at elaboration.
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
    parameter int                   OVERLAP   = 1,
    localparam int                  SW        = $clog2(PATTERN_W + 1)
) (
    input  logic [SW-1:0] state_i,
    input  logic          bit_i,
    output logic [SW-1:0] next_o
);

    // Every encoding of the state width gets an entry, so unused codes map to 0.
    logic [SW-1:0] tbl [2**(SW+1)];

    for (genvar s = 0; s < 2**SW; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int NXT = next_match_len(16'(PATTERN), PATTERN_W, OVERLAP, s, b);
            assign tbl[s*2+b] = SW'(NXT);
        end
    end

    assign next_o = tbl[{state_i, bit_i}];

endmodule

// File: rtl/fsm_moore_1010_det.sv
// Overlapping Moore sequence detector: state register, reset and output decode.
module fsm_moore_1010_det
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W = DEFAULT_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = DEFAULT_PATTERN,
    parameter int                   OVERLAP   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic data_out
);

    localparam int SW = $clog2(PATTERN_W + 1);

    logic [SW-1:0] current_state;
    logic [SW-1:0] next_state;

    seq_det_next_state #(
        .PATTERN_W (PATTERN_W),
        .PATTERN   (PATTERN),
        .OVERLAP   (OVERLAP)
    ) u_next (
        .state_i (current_state),
        .bit_i   (data_in),
        .next_o  (next_state)
    );

    // State register; reset wins over the sampled bit and discards progress.
    always_ff @(posedge clk) begin
        if (rst) current_state <= '0;
        else     current_state <= next_state;
    end

    // Moore output: decoded from the register only.
    assign data_out = (current_state == SW'(PATTERN_W));

endmodule

// File: tb/tb_fsm_moore_1010_det.sv
// Directed bench for the serial sequence detector (default, non-overlap, 1101).
module tb_fsm_moore_1010_det;
    import seq_det_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic data_in;
    logic out_ov, out_no, out_alt;

    always #5 clk = ~clk;

    fsm_moore_1010_det dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(out_ov)
    );
    fsm_moore_1010_det #(.OVERLAP(0)) dut_no (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(out_no)
    );
    fsm_moore_1010_det #(.PATTERN_W(4), .PATTERN(4'b1101)) dut_alt (
        .clk(clk), .rst(rst), .data_in(data_in), .data_out(out_alt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // ---------------- driver ----------------
    // Apply inputs, take one rising edge, then settle 1 time unit past it.
    task automatic tick(input logic b, input logic r);
        rst     = r;
        data_in = b;
        @(posedge clk);
        #1;
    endtask

    // Feed a bit list and compare state/output of one chosen instance per edge.
    // sel: 0 = default overlap, 1 = non-overlap, 2 = pattern 1101
    task automatic run_seq(input string name, input int sel, input logic bits[],
                           input int exp_st[]);
        for (int i = 0; i < bits.size(); i++) begin
            int st, ov;
            tick(bits[i], 1'b0);
            case (sel)
                0:       begin st = int'(dut.current_state);     ov = int'(out_ov);  end
                1:       begin st = int'(dut_no.current_state);  ov = int'(out_no);  end
                default: begin st = int'(dut_alt.current_state); ov = int'(out_alt); end
            endcase
            check($sformatf("%s_st%0d", name, i + 1), st, exp_st[i]);
            check($sformatf("%s_out%0d", name, i + 1), ov, (exp_st[i] == 4) ? 1 : 0);
        end
    endtask

    logic main_bits[] = '{1,0,0,1,1,0,1,0,1,0,1};

    initial begin
        rst = 1'b1;
        data_in = 1'b0;
        @(negedge clk);

        // Reset with data_in=1: reset wins.
        tick(1'b1, 1'b1);
        check("rst_state", int'(dut.current_state), int'(S0));
        check("rst_out", int'(out_ov), 0);
        tick(1'b1, 1'b0);
        check("post_rst_state", int'(dut.current_state), int'(S1));

        // Main stream, overlapping.
        tick(1'b0, 1'b1);
        run_seq("main", 0, main_bits, '{1,2,0,1,1,2,3,4,3,4,3});

        // Same stream, overlap disabled.
        tick(1'b0, 1'b1);
        run_seq("noov", 1, main_bits, '{1,2,0,1,1,2,3,4,1,2,3});

        // Near misses.
        tick(1'b0, 1'b1);
        run_seq("near", 0, '{1,0,1,1,0,0}, '{1,2,3,1,2,0});

        // Reset mid-match, then a fresh match.
        tick(1'b0, 1'b1);
        run_seq("pre", 0, '{1,0,1}, '{1,2,3});
        tick(1'b0, 1'b1);
        check("mid_rst_state", int'(dut.current_state), int'(S0));
        check("mid_rst_out", int'(out_ov), 0);
        run_seq("fresh", 0, '{1,0,1,0}, '{1,2,3,4});
        tick(1'b0, 1'b0);
        check("fresh_tail_state", int'(dut.current_state), int'(S0));
        check("fresh_tail_out", int'(out_ov), 0);

        // Alternate pattern 1101 (border 1).
        tick(1'b0, 1'b1);
        run_seq("alt", 2, '{1,1,0,1,1,0,1}, '{1,2,3,4,2,3,4});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm_moore_1010_det.md
# fsm_moore_1010_det

Overlapping serial sequence detector, Moore style, default pattern 1010. It samples one input bit per clock and raises a one-cycle flag in the cycle after the final pattern bit is sampled. It sits on a single-bit serial stream as a leaf block, and its output feeds control or status logic.

## Interface
- `PATTERN_W`, default 4: pattern length in bits; legal range 2..16.
- `PATTERN`, default 4'b1010: target sequence. The MSB is the first bit received.
- `OVERLAP`, default 1: 1 lets a match's suffix seed the next match; 0 restarts from idle after a match.
- `clk`  input  1: the only clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `data_in`  input  1: serial data, sampled on each rising edge of `clk`.
- `data_out`  output  1: high while the state register holds "full pattern matched".
- Port order is fixed as `clk`, `rst`, `data_in`, `data_out` for positional instantiation.
- Internal state register is named `current_state`. Benches probe it hierarchically.

## Operation
- State encodes the number of pattern bits currently matched, 0..PATTERN_W.
  - Width is $clog2(PATTERN_W+1); the default is 3 bits.
  - Default names: S0=0 idle, S1=1 "1", S2=2 "10", S3=3 "101", S4=4 "1010" (detect).
- Next state from state k < PATTERN_W with bit b is the length of the longest suffix of (first k pattern bits, then b) that is also a pattern prefix. KMP-style.
- Next state from state PATTERN_W:
  - OVERLAP=1: apply the same suffix rule, starting from the longest proper border of the pattern.
  - OVERLAP=0: apply the rule from state 0.
- Default transition table (OVERLAP=1), listed as input 0 / input 1:
  - S0: stay S0 / go S1
  - S1: go S2 / stay S1
  - S2: go S0 / go S3
  - S3: go S4 / go S1
  - S4: go S0 / go S3
- `data_out` = (current_state == PATTERN_W).
  - Decoded purely from the state register, Moore style; it does not depend combinationally on `data_in`.
- Next-state logic is computed at elaboration, via a constant function or a generated table. It is not hand-coded per pattern.
- Unused state encodings (5..7 in the default build) go to S0 on the next edge, with `data_out` low.
- X/Z on `data_in` needs no defined behaviour. The bench must not drive X outside reset.

## Timing
- Reset:
  - `rst` high at a rising edge sets `current_state` to S0; `data_out` is then 0.
  - `rst` takes priority over `data_in` on that edge.
  - Reset mid-match discards all progress.
- Latency: the edge that samples the last pattern bit loads S4. `data_out` is high for the following full cycle.
- With continued matching input, pulses can occur on cycles separated by PATTERN_W − border length; 2 cycles for 1010.
- There is no handshake and no enable: every rising edge consumes one bit.
- No combinational path from `data_in` to `data_out`.

## Structure
- Shared package `seq_det_pkg` holds:
  - the default-pattern state constants S0..S4 and the state width;
  - the default pattern constant 4'b1010;
  - the function computing the next-match length.
- Natural split: one sub-module `seq_det_next_state`, combinational, mapping (state, bit) to next state, parameterized on PATTERN/PATTERN_W/OVERLAP.
- The top holds the state register, the reset, and the output decode.

## Test plan
- Reset: hold `rst`=1 for one edge with `data_in`=1 -> `current_state`=S0, `data_out`=0; the following edge with `data_in`=1 -> S1.
- Main stream: after reset, feed 1,0,0,1,1,0,1,0,1,0,1, one bit per edge.
  - State trace: S1,S2,S0,S1,S1,S2,S3,S4,S3,S4,S3.
  - `data_out` is high only in the cycles after bits 8 and 10.
- Overlap off: same stream with OVERLAP=0 -> single pulse after bit 8; after bit 10 the state is S2 and `data_out`=0.
- Near misses: input 1,0,1,1,0,0 -> states S1,S2,S3,S1,S2,S0; `data_out` never asserts.
- Reset mid-match: input 1,0,1, then `rst`=1 on the edge that would sample 0 -> S0, no pulse. A fresh 1,0,1,0 then pulses once.
- Alternate pattern: PATTERN=4'b1101, PATTERN_W=4, input 1,1,0,1,1,0,1 -> pulses after bit 4 and bit 7.
